uart_rx: RTL and testbench

UART receive path for the 50 MHz system clock domain: accepts the asynchronous serial line, recovers 8N1 frames at 115200 baud using an internal mid-bit sampling counter, and presents each received byte as a one-cycle strobe. It is the receive-side counterpart of the transmit baud generation path. It shares the same divisor arithmetic: 434 clocks per bit, matching the 217-cycle half period used to generate the 115200 baud clock.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 112 +++++++++++
 tb/tb_uart_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and divisor helper
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Single place where the bit period is derived so TX and RX cannot diverge.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - 2-FF synchronizer with asynchronous reset to a chosen level
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_bad_rate
    $error("uart_rx: CLK_FREQ/BAUD must be at least 8");
  end

  logic             rxd_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            if (!rxd_s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rxd_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          // Hold off until the line returns high so a stuck-low line is one error.
          if (rxd_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed 8N1 frames
module tb_uart_rx;

  localparam int CPB       = 434;
  localparam longint LATENCY = 4126;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    longint      cyc;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  bit     prev_pulse = 1'b0;

  uart_rx dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst_n && (rx_valid || frame_err)) begin
      check("exclusive_pulses", longint'(rx_valid & frame_err), 0);
      check("no_consecutive_pulses", longint'(prev_pulse), 0);
      if (sb.size() == 0) begin
        check("spurious_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_frame_err", longint'(frame_err), longint'(mon_e.is_err));
        check("rx_data", longint'(rx_data), longint'(mon_e.data));
        check("pulse_cycle", cyc, mon_e.cyc);
      end
    end
    prev_pulse = rst_n && (rx_valid || frame_err);
  end

  // All drivers are entered and left on a negedge.
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit,
                            input bit is_err, input logic [7:0] exp_data);
    logic [9:0] bits;
    exp_t e;
    bits     = {stop_bit, b, 1'b0};
    e.is_err = is_err;
    e.data   = exp_data;
    e.cyc    = cyc + LATENCY;
    sb.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (cpb) @(negedge sys_clk);
    end
  endtask

  initial begin
    logic [9:0] abort_bits;
    int         guard;

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("reset_rx_data", longint'(rx_data), 0);
    check("reset_rx_valid", longint'(rx_valid), 0);
    check("reset_frame_err", longint'(frame_err), 0);
    rst_n = 1'b1;
    idle(50);

    send_frame(8'h55, CPB, 1'b1, 1'b0, 8'h55);
    idle(500);

    send_frame(8'hA5, CPB, 1'b1, 1'b0, 8'hA5);
    send_frame(8'h3C, CPB, 1'b1, 1'b0, 8'h3C);
    idle(500);

    rxd = 1'b0;
    repeat (100) @(negedge sys_clk);
    idle(1000);
    send_frame(8'h81, CPB, 1'b1, 1'b0, 8'h81);
    idle(500);

    send_frame(8'hF0, CPB, 1'b0, 1'b1, 8'h81);
    rxd = 1'b0;
    repeat (10000) @(negedge sys_clk);
    idle(1000);
    send_frame(8'h0F, CPB, 1'b1, 1'b0, 8'h0F);
    idle(500);

    abort_bits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = abort_bits[i];
      repeat (CPB) @(negedge sys_clk);
    end
    rxd = abort_bits[5];
    repeat (CPB / 2) @(negedge sys_clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    @(negedge sys_clk);
    check("midframe_reset_rx_data", longint'(rx_data), 0);
    check("midframe_reset_rx_valid", longint'(rx_valid), 0);
    check("midframe_reset_frame_err", longint'(frame_err), 0);
    repeat (4) @(negedge sys_clk);
    rst_n = 1'b1;
    idle(1000);
    send_frame(8'h7E, CPB, 1'b1, 1'b0, 8'h7E);
    idle(500);

    send_frame(8'h96, 425, 1'b1, 1'b0, 8'h96);
    idle(500);
    send_frame(8'h96, 443, 1'b1, 1'b0, 8'h96);
    idle(500);

    guard = 0;
    while (sb.size() != 0 && guard < 10000) begin
      @(negedge sys_clk);
      guard++;
    end
    check("scoreboard_drained", longint'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
